// File: rtl/inst_mem_resp_pkg.sv
// Shared bus widths, FSM encoding and constants for the instruction-fetch responder.
package inst_mem_resp_pkg;

  localparam int unsigned INST_ADDR_BUS_W = 32;
  localparam int unsigned INST_BUS_W      = 32;
  localparam int unsigned CNT_W           = 4;

  localparam logic [INST_BUS_W-1:0] ZERO_WORD = '0;

  // IDLE: serving hits or detecting a miss; WAIT: counting down a fill
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/inst_mem_array.sv
// DEPTH x 32 instruction store: one synchronous write port, asynchronous read port(s).
// INST_MEM_PAIRFILL_EN adds a second read port for the neighbouring word.
module inst_mem_array
  import inst_mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] wr_idx,
  input  logic [INST_BUS_W-1:0] wr_data,
  input  logic [DEPTH_LOG2-1:0] rd_idx0,
  output logic [INST_BUS_W-1:0] rd_data0
`ifdef INST_MEM_PAIRFILL_EN
  ,
  input  logic [DEPTH_LOG2-1:0] rd_idx1,
  output logic [INST_BUS_W-1:0] rd_data1
`endif
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [INST_BUS_W-1:0] mem [DEPTH];

  // Loader write commits at the clock edge; contents are never reset
  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_data;
  end

  assign rd_data0 = mem[rd_idx0];
`ifdef INST_MEM_PAIRFILL_EN
  assign rd_data1 = mem[rd_idx1];
`endif

endmodule

// File: rtl/inst_mem_resp.sv
// Instruction-fetch responder: slow backing store behind a small fetch buffer.
// Misses stall the pipeline for LATENCY+2 cycles. Optional macro
// INST_MEM_PAIRFILL_EN turns the buffer into two entries filled as a word pair.
module inst_mem_resp
  import inst_mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ce_i,
  input  logic [INST_ADDR_BUS_W-1:0] addr_i,
  output logic [INST_BUS_W-1:0]      inst_o,
  output logic                       stallreq_o,
  input  logic                       load_we_i,
  input  logic [INST_ADDR_BUS_W-1:0] load_addr_i,
  input  logic [INST_BUS_W-1:0]      load_data_i
);

  localparam int unsigned IDX_W = DEPTH_LOG2;
`ifdef INST_MEM_PAIRFILL_EN
  localparam int unsigned NBUF = 2;
`else
  localparam int unsigned NBUF = 1;
`endif

  logic [IDX_W-1:0] idx, load_idx;
  assign idx      = addr_i[IDX_W+1:2];
  assign load_idx = load_addr_i[IDX_W+1:2];

  // Byte-lane and aliasing address bits carry no information here
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[1:0], addr_i[INST_ADDR_BUS_W-1:IDX_W+2],
                              load_addr_i[1:0], load_addr_i[INST_ADDR_BUS_W-1:IDX_W+2]};

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      req_tag_q, req_tag_d;
  logic [NBUF-1:0]       buf_valid_q, buf_valid_d;
  logic [IDX_W-1:0]      buf_tag_q  [NBUF];
  logic [IDX_W-1:0]      buf_tag_d  [NBUF];
  logic [INST_BUS_W-1:0] buf_data_q [NBUF];
  logic [INST_BUS_W-1:0] buf_data_d [NBUF];
  logic [IDX_W-1:0]      fill_tag   [NBUF];
  logic [INST_BUS_W-1:0] rd_data    [NBUF];
  logic                  hit;
  logic [INST_BUS_W-1:0] hit_data;
  logic                  fill;
  logic                  wr_req;

  inst_mem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk      (clk),
    .we       (load_we_i),
    .wr_idx   (load_idx),
    .wr_data  (load_data_i),
    .rd_idx0  (fill_tag[0]),
    .rd_data0 (rd_data[0])
`ifdef INST_MEM_PAIRFILL_EN
    ,
    .rd_idx1  (fill_tag[1]),
    .rd_data1 (rd_data[1])
`endif
  );

  // Fill targets: the requested word and, in pair mode, its wrapped successor
  always_comb begin
    for (int i = 0; i < int'(NBUF); i++) fill_tag[i] = req_tag_q + IDX_W'(i);
  end

  // Buffer lookup for the current fetch address
  always_comb begin
    hit      = 1'b0;
    hit_data = ZERO_WORD;
    for (int i = 0; i < int'(NBUF); i++) begin
      if (buf_valid_q[i] && (buf_tag_q[i] == idx)) begin
        hit      = 1'b1;
        hit_data = buf_data_q[i];
      end
    end
  end

  // Core-facing outputs; forced quiet while reset is held
  always_comb begin
    inst_o     = ZERO_WORD;
    stallreq_o = 1'b0;
    if (!rst && ce_i) begin
      if (hit) inst_o     = hit_data;
      else     stallreq_o = 1'b1;
    end
  end

  // Next-state: miss detection, restart on address change or loader hit, fill
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_tag_d = req_tag_q;
    fill      = 1'b0;
    wr_req    = load_we_i && (load_idx == req_tag_q);
    case (state_q)
      IDLE: begin
        if (ce_i && !hit) begin
          state_d   = WAIT;
          cnt_d     = CNT_W'(LATENCY);
          req_tag_d = idx;
        end
      end
      WAIT: begin
        if (!ce_i) begin
          state_d = IDLE;
        end else if ((idx != req_tag_q) || wr_req) begin
          cnt_d     = CNT_W'(LATENCY);
          req_tag_d = idx;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          fill    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Buffer update: loader invalidation per entry, fill overrides; a same-edge
  // write to a freshly filled word drops that entry so stale data never survives
  always_comb begin
    for (int i = 0; i < int'(NBUF); i++) begin
      buf_valid_d[i] = buf_valid_q[i] && !(load_we_i && (load_idx == buf_tag_q[i]));
      buf_tag_d[i]   = buf_tag_q[i];
      buf_data_d[i]  = buf_data_q[i];
      if (fill) begin
        buf_tag_d[i]   = fill_tag[i];
        buf_data_d[i]  = rd_data[i];
        buf_valid_d[i] = !(load_we_i && (load_idx == fill_tag[i]));
      end
    end
  end

  // Control state with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_tag_q   <= '0;
      buf_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_tag_q   <= req_tag_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  // Buffer tag/data payload, qualified by buf_valid so no reset needed
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NBUF); i++) begin
      buf_tag_q[i]  <= buf_tag_d[i];
      buf_data_q[i] <= buf_data_d[i];
    end
  end

endmodule

// File: tb/tb_inst_mem_resp.sv
// Self-checking bench for inst_mem_resp: directed scenarios then random traffic,
// all cycles compared against a timestamp-based reference model of the fetch buffer.
module tb_inst_mem_resp;

  localparam int DL  = 10;
  localparam int D   = 1 << DL;
  localparam int LAT = 2;
`ifdef INST_MEM_PAIRFILL_EN
  localparam int NE = 2;
`else
  localparam int NE = 1;
`endif
  localparam int MISS = LAT + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce_i;
  logic [31:0] addr_i;
  logic [31:0] inst_o;
  logic        stallreq_o;
  logic        load_we_i;
  logic [31:0] load_addr_i;
  logic [31:0] load_data_i;

  inst_mem_resp #(.DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .ce_i        (ce_i),
    .addr_i      (addr_i),
    .inst_o      (inst_o),
    .stallreq_o  (stallreq_o),
    .load_we_i   (load_we_i),
    .load_addr_i (load_addr_i),
    .load_data_i (load_data_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  longint cyc = 0;

  // Reference model: memory image, buffer entries, pending fetch with its due cycle
  logic [31:0] mm [D];
  bit          mv [2];
  int          mt [2];
  logic [31:0] md [2];
  bit          pend;
  int          ptag;
  longint      pdue;

  logic [31:0] last_inst;
  logic        last_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[DL+1:2]);
  endfunction

  function automatic bit mhit(input int ix, output logic [31:0] d);
    d = '0;
    for (int e = 0; e < NE; e++)
      if (mv[e] && mt[e] == ix) begin
        d = md[e];
        return 1'b1;
      end
    return 1'b0;
  endfunction

  // Apply one clock edge worth of behaviour to the model
  task automatic model_edge();
    int ix, wi, t;
    bit h;
    logic [31:0] d;
    ix = widx(addr_i);
    wi = load_we_i ? widx(load_addr_i) : -1;
    if (rst) begin
      mv[0] = 0; mv[1] = 0; pend = 0;
    end else begin
      h = mhit(ix, d);
      for (int e = 0; e < NE; e++) if (mv[e] && mt[e] == wi) mv[e] = 0;
      if (!pend) begin
        if (ce_i && !h) begin pend = 1; ptag = ix; pdue = cyc + LAT + 1; end
      end else if (!ce_i) begin
        pend = 0;
      end else if (ix != ptag || wi == ptag) begin
        ptag = ix; pdue = cyc + LAT + 1;
      end else if (cyc == pdue) begin
        for (int e = 0; e < NE; e++) begin
          t = (ptag + e) % D;
          mt[e] = t; md[e] = mm[t]; mv[e] = (wi != t);
        end
        pend = 0;
      end
    end
    if (load_we_i) mm[wi] = load_data_i;
  endtask

  // Called at negedge with inputs already driven: check, update model, advance
  task automatic cycle();
    logic [31:0] ei, d;
    logic es;
    #1;
    ei = '0; es = 1'b0;
    if (!rst && ce_i) begin
      if (mhit(widx(addr_i), d)) ei = d;
      else es = 1'b1;
    end
    chk("inst", inst_o, ei);
    chk("stall", 32'(stallreq_o), 32'(es));
    last_inst  = inst_o;
    last_stall = stallreq_o;
    model_edge();
    @(negedge clk);
    cyc++;
  endtask

  // Hold the current fetch until served; report stall cycles and returned word
  task automatic measure(input string tag, input int exp_stalls, input logic [31:0] exp_inst);
    int n;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (last_stall) n++;
      else break;
    end
    chk({tag, "_stalls"}, 32'(n), 32'(exp_stalls));
    chk({tag, "_inst"}, last_inst, exp_inst);
  endtask

  task automatic fetch(input logic [31:0] a);
    ce_i = 1'b1; addr_i = a; load_we_i = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int w;
    int words [8] = '{0, 1, 2, 3, 4, 5, 1022, 1023};
    rst = 1'b1; ce_i = 1'b0; addr_i = '0;
    load_we_i = 1'b0; load_addr_i = '0; load_data_i = '0;
    mv[0] = 0; mv[1] = 0; pend = 0; ptag = 0; pdue = 0;
    @(negedge clk);
    cycle();
    chk("reset_inst", last_inst, 32'h0);
    chk("reset_stall", 32'(last_stall), 32'h0);
    rst = 1'b0;

    // Preload whole array
    for (int i = 0; i < D; i++) begin
      load_we_i = 1'b1; load_addr_i = 32'(i) << 2;
      load_data_i = (i == 0) ? 32'h34011100 : (i == 2) ? 32'h00000001 : $urandom();
      cycle();
    end
    load_we_i = 1'b0;

    // Reset in WAIT with cnt=1
    fetch(32'h0);
    cycle(); cycle();
    rst = 1'b1;
    cycle();
    chk("rst_wait_inst", last_inst, 32'h0);
    chk("rst_wait_stall", 32'(last_stall), 32'h0);
    rst = 1'b0;
    measure("after_rst", MISS, 32'h34011100);
    measure("hold_hit", 0, 32'h34011100);
    measure("hold_hit2", 0, 32'h34011100);

    // Address change mid-WAIT
    fetch(32'h10);
    cycle();
    fetch(32'h14);
    measure("addr_change", MISS, mm[5]);

    // Coherence: write to buffered word
    fetch(32'h8);
    measure("fill8", MISS, 32'h00000001);
    ce_i = 1'b0; load_we_i = 1'b1; load_addr_i = 32'h8; load_data_i = 32'hDEADBEEF;
    cycle();
    fetch(32'h8);
    measure("inval8", MISS, 32'hDEADBEEF);
    // Coherence: write to word under fill
    ce_i = 1'b0; load_we_i = 1'b1; load_addr_i = 32'h8; load_data_i = 32'h00000001;
    cycle();
    fetch(32'h8);
    cycle();
    load_we_i = 1'b1; load_addr_i = 32'h8; load_data_i = 32'hDEADBEEF;
    cycle();
    load_we_i = 1'b0;
    measure("wr_in_wait", LAT + 1, 32'hDEADBEEF);

    // ce low and abort
    ce_i = 1'b0; addr_i = 32'h0;
    cycle();
    chk("ce_low_inst", last_inst, 32'h0);
    chk("ce_low_stall", 32'(last_stall), 32'h0);
    fetch(32'h40);
    cycle(); cycle();
    ce_i = 1'b0;
    cycle(); cycle();
    fetch(32'h40);
    measure("abort_refetch", MISS, mm[16]);

    // Pair fill behaviour (single-entry build expects a second miss)
    fetch(32'h100);
    measure("pair_first", MISS, mm[64]);
    fetch(32'h104);
    measure("pair_second", (NE == 2) ? 0 : MISS, mm[65]);
    fetch(32'hFFC);
    measure("wrap_last", MISS, mm[1023]);
    fetch(32'h0);
    measure("wrap_zero", (NE == 2) ? 0 : MISS, mm[0]);

    // Random traffic with aliasing addresses, loader writes and rare resets
    w = 0;
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      ce_i = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 9) < 3) w = words[$urandom_range(0, 7)];
      a = $urandom(); a[DL+1:2] = DL'(w); addr_i = a;
      load_we_i = ($urandom_range(0, 9) == 0);
      a = $urandom(); a[DL+1:2] = DL'(words[$urandom_range(0, 7)]); load_addr_i = a;
      load_data_i = $urandom();
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_mem_resp.md
Name: inst_mem_resp

Overview:
- Instruction-fetch responder for the openmips core: the memory side of the core's fetch interface (ce, addr in; inst out).
- Unlike the zero-wait combinational ROM, it models a slow backing store with a programmable wait-state count.
- A one-word fetch buffer returns hits with no wait. A miss raises a stall request to the pipeline controller until the fill completes.
- A loader write port lets the bench or boot logic program the array at run time.

Parameters:
DEPTH_LOG2, 10, log2 of array depth in 32-bit words (1024 words)
LATENCY, 2, wait cycles added per miss (0..15)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
ce_i  in  1  fetch enable from core (rom_ce)
addr_i  in  32  byte fetch address from core; bits [1:0] ignored
inst_o  out  32  instruction returned to core
stallreq_o  out  1  stall request to pipeline controller; high while a fetch is not served
load_we_i  in  1  loader write strobe
load_addr_i  in  32  loader byte address; bits [1:0] ignored
load_data_i  in  32  loader write data

Behaviour:
- Clock is clk, reset is rst: one clock, asynchronous active-high reset.
- Word index = addr[DEPTH_LOG2+1:2]. Upper address bits are ignored, so addresses alias modulo the depth.
- Array: DEPTH words, never reset; contents are X until written. A loader write commits at the clk edge.
- State: buf_valid, buf_tag (word index), buf_data, FSM {IDLE, WAIT}, 4-bit cnt.
- Reset (asynchronous): buf_valid=0, FSM=IDLE, cnt=0. While rst=1, inst_o=0 and stallreq_o=0.
- Outputs are combinational from state plus ce_i and addr_i:
  - ce_i=0: inst_o=0, stallreq_o=0; the FSM returns to IDLE (abort) at the next edge.
  - ce_i=1 and hit (buf_valid && buf_tag==index): inst_o=buf_data, stallreq_o=0.
  - ce_i=1 and miss: inst_o=0, stallreq_o=1.
- IDLE with miss: at the edge, go to WAIT and latch cnt=LATENCY and req_tag=index.
- WAIT:
  - If index != req_tag (core changed address), or ce_i=0: restart (cnt=LATENCY, req_tag=index) or abort to IDLE respectively.
  - Else if cnt != 0: cnt--.
  - Else: load buf_data=array[req_tag], buf_tag=req_tag, buf_valid=1, go to IDLE.
- Miss cost: stallreq_o is high for exactly LATENCY+2 cycles. The instruction is presented in the following cycle with stall low.
- Loader write coherence:
  - A write whose index equals buf_tag clears buf_valid at the same edge.
  - A write whose index equals req_tag while in WAIT restarts cnt=LATENCY, so the fill returns the new data.
  - Writes to other indices do not disturb an in-progress fill.
- Write and fill to the same index in the same edge: the restart rule wins; no stale data is ever buffered.

Optional Feature:
- Macro INST_MEM_PAIRFILL_EN.
- Defined:
  - The buffer holds two entries.
  - A fill loads array[req_tag] and array[(req_tag+1) mod DEPTH] at once.
  - A hit on either entry returns with no wait, so straight-line code misses at most every second word.
  - Loader invalidation applies to each entry independently.
- Undefined: single-entry buffer as described above.

Decomposition:
- Shared package/defines file (alongside the existing bus-width defines) holds:
  - InstAddrBus and InstBus widths.
  - FSM state encodings (IDLE=1'b0, WAIT=1'b1).
  - ZeroWord constant.
- One natural sub-module, inst_mem_array: the DEPTH x 32 storage with one write port and one (two with INST_MEM_PAIRFILL_EN) asynchronous read ports.

Test Plan:
1. Reset during WAIT: with ce_i=1, a miss in progress and cnt=1, assert rst -> inst_o=0 and stallreq_o=0 immediately; after release, buf_valid=0 and a fetch of 0x0 misses again.
2. LATENCY=2: load 0x0=0x34011100; ce_i=1, addr_i=0x0 -> stallreq_o=1 for 4 cycles, then inst_o=0x34011100 with stall=0; holding addr gives further hits with no wait.
3. Address change mid-WAIT: miss on 0x0, then addr_i=0x4 after 1 cycle -> counter restarts; the fill returns array[1], and the total stall from the change is 4 cycles.
4. Coherence:
   - With 0x8 buffered (0x00000001), loader writes 0x8=0xDEADBEEF -> next fetch of 0x8 misses and returns 0xDEADBEEF.
   - A write to 0x8 during its WAIT -> the returned data is 0xDEADBEEF, never the old value.
5. ce_i=0 with addr_i=0x0 -> inst_o=0 and stallreq_o=0; toggling ce_i high mid-WAIT then low -> FSM back in IDLE with no buffer update.
6. INST_MEM_PAIRFILL_EN:
   - Fetch 0x0 then 0x4 -> only the first fetch stalls (4 cycles); 0x4 hits.
   - Fetch 0xFFC with DEPTH_LOG2=10 -> the pair wraps to word 0.
